conv_out_streamer: RTL and testbench
====================================

CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 SHALL have parameter input_size, default 7, meaning the input feature-map edge length of the upstream convolution stage.
REQ-002 SHALL have parameter filter_size, default 5, meaning the convolution kernel edge length.
REQ-003 SHALL have parameter stride, default 2, meaning the convolution stride; derived OUT_DIM = ((input_size-filter_size)/stride)+1 and OUT_N = OUT_DIM*OUT_DIM (default 4).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port frame_valid, input, 1, meaning frame_data holds a complete convolution result.
REQ-007 SHALL have port frame_ready, output, 1, meaning the block can capture a frame this cycle.
REQ-008 SHALL have port frame_data, input, OUT_N*32, meaning packed results; element k occupies bits [32k+31:32k], signed fixed point (1 sign, 16 integer, 15 fraction).
REQ-009 SHALL have port out_valid, output, 1, meaning out_data, out_index and out_last are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the current element.
REQ-011 SHALL have port out_data, output, 32, meaning the current element in the same fixed-point format.
REQ-012 SHALL have port out_index, output, clog2(OUT_N) (minimum 1), meaning the index k of the current element.
REQ-013 SHALL have port out_last, output, 1, meaning the current element is index OUT_N-1.
REQ-014 SHALL have port frame_count, output, 16, meaning the number of frames fully streamed since reset.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and STREAM.
REQ-016 SHALL drive frame_ready=1 only in IDLE and out_valid=1 only in STREAM.
REQ-017 SHALL, in IDLE with frame_valid=1, register all of frame_data into an internal OUT_N x 32 buffer, clear the index to 0, and enter STREAM on the next edge.
REQ-018 SHALL not capture frame_data in STREAM, and SHALL not alter the buffer while streaming, regardless of frame_valid.
REQ-019 SHALL present buffer[index] on out_data in STREAM, with first out_valid one cycle after the capture handshake.
REQ-020 SHALL increment the index on each cycle with out_valid and out_ready both high; out_data, out_index and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 SHALL assert out_last exactly when the index equals OUT_N-1.
REQ-022 SHALL, on the out_last handshake, return to IDLE and increment frame_count, which wraps from 0xFFFF to 0x0000.
REQ-023 SHALL insert exactly one IDLE cycle between frames; a frame presented during the last beat is captured in the following cycle.
REQ-024 SHALL stream elements in ascending index order, with no reordering or arithmetic except as defined in REQ-029 and REQ-030.

Reset
REQ-025 SHALL, when rst is asserted, immediately force state to IDLE, index to 0, frame_count to 0, and the buffer to 0.
REQ-026 SHALL drive frame_ready=1, out_valid=0, out_data=0, out_index=0 and out_last=0 while in reset.
REQ-027 SHALL, on reset asserted mid-stream, drop the partial frame with no further out_valid and no frame_count increment.
REQ-028 SHALL accept a new frame on the first clock edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro CONV_OUT_RELU_EN defined, replace any buffered element with bit 31 set by 0x00000000 on out_data; positive values and zero pass unchanged.
REQ-030 SHALL, without CONV_OUT_RELU_EN, pass all elements unchanged, including negative ones.

Verification
REQ-031 SHALL cover the defaults with frame {0x00008000, 0x00010000, 0x00000000, 0x00018000} and out_ready held at 1 -> four beats on consecutive cycles, index 0..3 with those values, out_last on beat 3, frame_count=1.
REQ-032 SHALL cover out_ready toggling 1,0,0,1,... -> each element held stable while stalled, no element skipped or duplicated.
REQ-033 SHALL cover element 1 = 0xFFFF8000 (-1.0) -> out_data 0x00000000 with CONV_OUT_RELU_EN defined, and 0xFFFF8000 without it.
REQ-034 SHALL cover frame_valid held high continuously across two frames with different data -> the second frame is captured only after the first frame's out_last handshake plus one IDLE cycle, and frame_count=2.
REQ-035 SHALL cover rst pulsed after beat 1 of a frame -> out_valid low at once, frame_count=0, and the next frame streams from index 0.

Source files
------------

// File: rtl/conv_out_streamer.sv
// conv_out_streamer: captures a packed convolution result and streams it one element per handshake.
// Optional CONV_OUT_RELU_EN clamps negative elements to zero on out_data.
module conv_out_streamer #(
   parameter int input_size  = 7,
   parameter int filter_size = 5,
   parameter int stride      = 2,
   localparam int OUT_DIM = ((input_size - filter_size) / stride) + 1,
   localparam int OUT_N   = OUT_DIM * OUT_DIM,
   localparam int IW      = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_valid,
   output logic              frame_ready,
   input  logic [OUT_N*32-1:0] frame_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [IW-1:0]     out_index,
   output logic              out_last,
   output logic [15:0]       frame_count
);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t                      state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [15:0]                 cnt_q, cnt_d;
   logic [OUT_N-1:0][31:0]      buf_q, buf_d;
   logic [31:0]                 raw, elem;
   logic                        last;
   always_comb begin
      raw = buf_q[idx_q];
`ifdef CONV_OUT_RELU_EN
      elem = raw[31] ? 32'h0 : raw;
`else
      elem = raw;
`endif
      last        = (state_q == STREAM) && (idx_q == IW'(OUT_N - 1));
      frame_ready = (state_q == IDLE);
      out_valid   = (state_q == STREAM);
      out_data    = out_valid ? elem : 32'h0;
      out_index   = idx_q;
      out_last    = last;
      frame_count = cnt_q;
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      if (state_q == IDLE) begin
         if (frame_valid) begin
            buf_d   = frame_data;
            idx_d   = '0;
            state_d = STREAM;
         end
      end else if (out_ready) begin
         // Index returns to 0 on the last beat so IDLE always shows index 0.
         idx_d   = last ? '0 : idx_q + IW'(1);
         state_d = last ? IDLE : STREAM;
         cnt_d   = last ? cnt_q + 16'd1 : cnt_q;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end
endmodule

// File: tb/tb_conv_out_streamer.sv
// tb_conv_out_streamer: directed checks of capture, streaming, stalls, back-to-back frames and reset.
module tb_conv_out_streamer;
   logic         clk = 1'b0;
   logic         rst, frame_valid, out_ready;
   logic [127:0] frame_data;
   logic         frame_ready, out_valid, out_last;
   logic [31:0]  out_data;
   logic [1:0]   out_index;
   logic [15:0]  frame_count;
   int cmp = 0;
   int err = 0;
   logic [31:0] fa [4] = '{32'h00008000, 32'h00010000, 32'h00000000, 32'h00018000};
   logic [31:0] fb [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
   logic [31:0] fs [4] = '{32'h00020000, 32'hFFFF8000, 32'h7FFFFFFF, 32'h00000001};
   logic [31:0] es [4];

   conv_out_streamer dut (
      .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_data(frame_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index), .out_last(out_last),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; frame_valid = 1'b0; out_ready = 1'b0; frame_data = '0;
      step; step;
      cmp++; if (frame_ready !== 1'b1) begin err++; $display("FAIL reset_frame_ready got %b want 1", frame_ready); end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      cmp++; if (out_data !== 32'h0) begin err++; $display("FAIL reset_out_data got %h want 0", out_data); end
      cmp++; if (out_index !== 2'd0) begin err++; $display("FAIL reset_out_index got %0d want 0", out_index); end
      cmp++; if (out_last !== 1'b0) begin err++; $display("FAIL reset_out_last got %b want 0", out_last); end
      cmp++; if (frame_count !== 16'd0) begin err++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      frame_data = {fa[3], fa[2], fa[1], fa[0]}; frame_valid = 1'b1; out_ready = 1'b1;
      cmp++; if (frame_ready !== 1'b1) begin err++; $display("FAIL basic_ready got %b want 1", frame_ready); end
      step;
      frame_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cmp++; if (out_valid !== 1'b1) begin err++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
         cmp++; if (out_index !== 2'(k)) begin err++; $display("FAIL basic_index[%0d] got %0d want %0d", k, out_index, k); end
         cmp++; if (out_data !== fa[k]) begin err++; $display("FAIL basic_data[%0d] got %h want %h", k, out_data, fa[k]); end
         cmp++; if (out_last !== (k == 3)) begin err++; $display("FAIL basic_last[%0d] got %b want %b", k, out_last, k == 3); end
         cmp++; if (frame_ready !== 1'b0) begin err++; $display("FAIL basic_ready_busy[%0d] got %b want 0", k, frame_ready); end
         step;
      end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL basic_idle_valid got %b want 0", out_valid); end
      cmp++; if (frame_ready !== 1'b1) begin err++; $display("FAIL basic_idle_ready got %b want 1", frame_ready); end
      cmp++; if (frame_count !== 16'd1) begin err++; $display("FAIL basic_count got %0d want 1", frame_count); end
   endtask

   task automatic test_stall_relu;
      int k, cyc;
      es = fs;
`ifdef CONV_OUT_RELU_EN
      es[1] = 32'h00000000;
`endif
      frame_data = {fs[3], fs[2], fs[1], fs[0]}; frame_valid = 1'b1;
      step;
      frame_valid = 1'b0;
      k = 0; cyc = 0;
      while (k < 4 && cyc < 40) begin
         out_ready = (cyc % 3 == 0);
         cmp++; if (out_valid !== 1'b1) begin err++; $display("FAIL stall_valid[c%0d] got %b want 1", cyc, out_valid); end
         cmp++; if (out_index !== 2'(k)) begin err++; $display("FAIL stall_index[c%0d] got %0d want %0d", cyc, out_index, k); end
         cmp++; if (out_data !== es[k]) begin err++; $display("FAIL stall_data[c%0d] got %h want %h", cyc, out_data, es[k]); end
         cmp++; if (out_last !== (k == 3)) begin err++; $display("FAIL stall_last[c%0d] got %b want %b", cyc, out_last, k == 3); end
         step;
         if (out_ready) k++;
         cyc++;
      end
      cmp++; if (k != 4) begin err++; $display("FAIL stall_timeout got %0d beats want 4", k); end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL stall_end_valid got %b want 0", out_valid); end
      cmp++; if (frame_count !== 16'd2) begin err++; $display("FAIL stall_count got %0d want 2", frame_count); end
      out_ready = 1'b1;
   endtask

   task automatic test_back_to_back;
      rst = 1'b1;
      #1;
      cmp++; if (frame_count !== 16'd0) begin err++; $display("FAIL b2b_rst_count got %0d want 0", frame_count); end
      rst = 1'b0;
      frame_data = {fa[3], fa[2], fa[1], fa[0]}; frame_valid = 1'b1; out_ready = 1'b1;
      step;
      frame_data = {fb[3], fb[2], fb[1], fb[0]};
      for (int k = 0; k < 4; k++) begin
         cmp++; if (out_valid !== 1'b1 || out_data !== fa[k]) begin err++; $display("FAIL b2b_a[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, fa[k]); end
         step;
      end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL b2b_gap_valid got %b want 0", out_valid); end
      cmp++; if (frame_ready !== 1'b1) begin err++; $display("FAIL b2b_gap_ready got %b want 1", frame_ready); end
      cmp++; if (frame_count !== 16'd1) begin err++; $display("FAIL b2b_gap_count got %0d want 1", frame_count); end
      step;
      for (int k = 0; k < 4; k++) begin
         cmp++; if (out_valid !== 1'b1 || out_index !== 2'(k) || out_data !== fb[k]) begin err++; $display("FAIL b2b_b[%0d] got v=%b i=%0d d=%h want v=1 i=%0d d=%h", k, out_valid, out_index, out_data, k, fb[k]); end
         step;
      end
      frame_valid = 1'b0;
      cmp++; if (frame_count !== 16'd2) begin err++; $display("FAIL b2b_count got %0d want 2", frame_count); end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL b2b_end_valid got %b want 0", out_valid); end
      step;
   endtask

   task automatic test_reset_mid;
      frame_data = {fa[3], fa[2], fa[1], fa[0]}; frame_valid = 1'b1; out_ready = 1'b1;
      step;
      frame_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cmp++; if (out_valid !== 1'b1 || out_data !== fa[k]) begin err++; $display("FAIL mid_pre[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, fa[k]); end
         step;
      end
      rst = 1'b1;
      #1;
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL mid_valid got %b want 0", out_valid); end
      cmp++; if (out_data !== 32'h0) begin err++; $display("FAIL mid_data got %h want 0", out_data); end
      cmp++; if (out_index !== 2'd0) begin err++; $display("FAIL mid_index got %0d want 0", out_index); end
      cmp++; if (frame_ready !== 1'b1) begin err++; $display("FAIL mid_ready got %b want 1", frame_ready); end
      cmp++; if (frame_count !== 16'd0) begin err++; $display("FAIL mid_count got %0d want 0", frame_count); end
      #1;
      rst = 1'b0;
      frame_data = {fb[3], fb[2], fb[1], fb[0]}; frame_valid = 1'b1;
      step;
      frame_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cmp++; if (out_valid !== 1'b1 || out_index !== 2'(k) || out_data !== fb[k]) begin err++; $display("FAIL mid_post[%0d] got v=%b i=%0d d=%h want v=1 i=%0d d=%h", k, out_valid, out_index, out_data, k, fb[k]); end
         step;
      end
      cmp++; if (frame_count !== 16'd1) begin err++; $display("FAIL mid_post_count got %0d want 1", frame_count); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall_relu;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
